mem_requester: RTL
==================

MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 SHALL have parameter: MEM_DEPTH, 16384, word count of the attached main memory; power of two; sets the address wrap point and range limit.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  asynchronous active-low reset (asserted at 0).
REQ-004 SHALL have port: req_valid  input  1  request offered.
REQ-005 SHALL have port: req_ready  output  1  request accepted when req_valid=1 and req_ready=1 at a clk edge.
REQ-006 SHALL have port: req_write  input  1  1=write, 0=read.
REQ-007 SHALL have port: req_addr  input  16  start word address.
REQ-008 SHALL have port: req_wdata  input  16  write data, single word.
REQ-009 SHALL have port: req_len  input  2  read burst beats minus one (1-4 beats); ignored for writes.
REQ-010 SHALL have port: rsp_valid  output  1  response beat offered.
REQ-011 SHALL have port: rsp_ready  input  1  response beat consumed when rsp_valid=1 and rsp_ready=1 at a clk edge.
REQ-012 SHALL have port: rsp_data  output  16  read data; 0 for write acks and errors.
REQ-013 SHALL have port: rsp_last  output  1  final beat of the transaction.
REQ-014 SHALL have port: rsp_err  output  1  address error on this beat.
REQ-015 SHALL have ports to memory: mem_addr  output  16; mem_data_in  output  16; mem_we  output  1; mem_data_out  input  16 (one-cycle registered read latency).
REQ-016 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement the FSM states IDLE, WR, RD_ADDR, RD_WAIT, RESP, ERR.
REQ-018 SHALL drive req_ready=1 only in IDLE; on accept, SHALL latch addr, wdata, len and write into registers.
REQ-019 On an accepted write, SHALL go IDLE->WR; in WR, SHALL drive mem_we=1, mem_addr=latched addr and mem_data_in=latched wdata for exactly one cycle, then go to RESP with rsp_data=0, rsp_last=1, rsp_err=0.
REQ-020 On an accepted read, SHALL go IDLE->RD_ADDR->RD_WAIT, capturing mem_data_out at the end of RD_WAIT into rsp_data, then go to RESP.
REQ-021 SHALL hold mem_addr stable from RD_ADDR through RD_WAIT, and SHALL hold mem_we=0 in every state except WR.
REQ-022 Read latency SHALL be: accept edge, then rsp_valid=1 in the third cycle after that edge.
REQ-023 In RESP, SHALL hold rsp_valid=1 and hold rsp_data, rsp_last and rsp_err stable until rsp_ready=1.
REQ-024 On the RESP handshake, SHALL go to IDLE when rsp_last=1; otherwise SHALL increment the address and go to RD_ADDR.
REQ-025 The burst address increment SHALL wrap modulo MEM_DEPTH on the low log2(MEM_DEPTH) bits, holding the upper bits (e.g. 0x3FFF->0x0000 at the default depth).
REQ-026 SHALL assert rsp_last only on beat req_len+1 of a read and on every write ack or error beat.
REQ-027 SHALL ignore a req_valid arriving while busy (req_ready=0); no request is queued.
REQ-028 SHALL drive rsp_valid=0 in every state other than RESP and ERR.

Reset
REQ-029 While reset=0, SHALL force state=IDLE asynchronously, with outputs rsp_valid=0, rsp_data=0, rsp_last=0, rsp_err=0, mem_we=0, mem_addr=0, mem_data_in=0, busy=0 and req_ready=0.
REQ-030 SHALL drive req_ready=1 from the first clk edge after reset deasserts.
REQ-031 A reset asserted mid-transaction SHALL abort it: no further memory write, pending response discarded.

Configuration
REQ-032 With macro MEM_REQUESTER_RANGE_CHECK_EN defined, an accepted request with req_addr >= MEM_DEPTH SHALL go IDLE->ERR, perform no memory access, and present one beat with rsp_valid=1, rsp_err=1, rsp_last=1, rsp_data=0, held until rsp_ready, then return to IDLE.
REQ-033 Without MEM_REQUESTER_RANGE_CHECK_EN, the ERR state SHALL be absent, rsp_err SHALL be tied to 0, and all addresses SHALL be forwarded unchecked.

Verification
REQ-034 Write 0xBEEF to 0x0010, then 1-beat read of 0x0010 -> exactly one mem_we pulse at 0x0010; then rsp_data=0xBEEF, rsp_last=1, three cycles after the read accept.
REQ-035 Preload 0x3FFE..0x3FFF=1,2 and 0x0000..0x0001=3,4; read addr 0x3FFE, len=3 -> beats 1,2,3,4, rsp_last only on the 4th.
REQ-036 Read burst with rsp_ready held 0 for 5 cycles on beat 2 -> rsp_data and rsp_valid stable throughout, no address advance, no beat lost.
REQ-037 With MEM_REQUESTER_RANGE_CHECK_EN defined, write to 0x4000 -> rsp_err=1, rsp_last=1, mem_we never asserted.
REQ-038 Assert reset during RD_WAIT of a 4-beat read -> rsp_valid=0 immediately; first post-reset request completes normally.

Source files
------------

// File: rtl/mem_requester.sv
// Single-outstanding memory requester: one-word writes and 1-4 beat read bursts over a valid/ready pair.
// Define MEM_REQUESTER_RANGE_CHECK_EN to reject request addresses >= MEM_DEPTH with an error beat.
module mem_requester #(
  parameter int MEM_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_len,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_we,
  input  logic [15:0] mem_data_out,
  output logic        busy
);

  localparam logic [15:0] ADDR_MASK = 16'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_ADDR = 3'd2,
    RD_WAIT = 3'd3,
`ifdef MEM_REQUESTER_RANGE_CHECK_EN
    ERR     = 3'd5,
`endif
    RESP    = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] addr;
  logic [1:0]  len;
  logic [1:0]  beat;

  // Burst addresses wrap inside the memory window and keep the bits above it.
  function automatic logic [15:0] next_addr(input logic [15:0] a);
    return (a & ~ADDR_MASK) | ((a + 16'd1) & ADDR_MASK);
  endfunction

`ifdef MEM_REQUESTER_RANGE_CHECK_EN
  logic err_q;
  assign rsp_err = err_q;

  function automatic logic out_of_range(input logic [15:0] a);
    return {16'd0, a} >= 32'(MEM_DEPTH);
  endfunction
`else
  assign rsp_err = 1'b0;
`endif

  // Request/response sequencer; every output is driven from a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      addr        <= 16'd0;
      len         <= 2'd0;
      beat        <= 2'd0;
      req_ready   <= 1'b0;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 16'd0;
      rsp_last    <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 16'd0;
      mem_data_in <= 16'd0;
`ifdef MEM_REQUESTER_RANGE_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr      <= req_addr;
            len       <= req_len;
            beat      <= 2'd0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef MEM_REQUESTER_RANGE_CHECK_EN
            if (out_of_range(req_addr)) begin
              state     <= ERR;
              rsp_valid <= 1'b1;
              rsp_data  <= 16'd0;
              rsp_last  <= 1'b1;
              err_q     <= 1'b1;
            end else
`endif
            if (req_write) begin
              state       <= WR;
              mem_we      <= 1'b1;
              mem_addr    <= req_addr;
              mem_data_in <= req_wdata;
            end else begin
              state    <= RD_ADDR;
              mem_addr <= req_addr;
            end
          end else begin
            // Also raises ready on the first edge after reset release.
            req_ready <= 1'b1;
          end
        end
        WR: begin
          mem_we    <= 1'b0;
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= 16'd0;
          rsp_last  <= 1'b1;
        end
        RD_ADDR: begin
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_data  <= mem_data_out;
          rsp_last  <= (beat == len);
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_data  <= 16'd0;
            rsp_last  <= 1'b0;
            if (rsp_last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              state    <= RD_ADDR;
              addr     <= next_addr(addr);
              mem_addr <= next_addr(addr);
              beat     <= beat + 2'd1;
            end
          end
        end
`ifdef MEM_REQUESTER_RANGE_CHECK_EN
        ERR: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            err_q     <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
`endif
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          req_ready <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_data  <= 16'd0;
          rsp_last  <= 1'b0;
          mem_we    <= 1'b0;
`ifdef MEM_REQUESTER_RANGE_CHECK_EN
          err_q     <= 1'b0;
`endif
        end
      endcase
    end
  end

endmodule
